// File: rtl/serial_addsub_engine_if.sv
// Handshake/operand bundle for serial_addsub_engine; master drives start and operands, slave returns result.
// Optional acc_sas_i exists only when SAS_ACCUM_EN is defined.
interface serial_addsub_engine_if #(
  parameter int WIDTH = 8
);
`ifdef SAS_ACCUM_EN
  logic             acc_sas_i;
`endif
  logic             start_sas_i;
  logic             mode_sas_i;
  logic [WIDTH-1:0] a_sas_i;
  logic [WIDTH-1:0] b_sas_i;
  logic             busy_sas_o;
  logic             done_sas_o;
  logic [WIDTH:0]   final_sum_o;
  logic             ovf_sas_o;

  modport master (
`ifdef SAS_ACCUM_EN
    output acc_sas_i,
`endif
    output start_sas_i, mode_sas_i, a_sas_i, b_sas_i,
    input  busy_sas_o, done_sas_o, final_sum_o, ovf_sas_o
  );

  modport slave (
`ifdef SAS_ACCUM_EN
    input  acc_sas_i,
`endif
    input  start_sas_i, mode_sas_i, a_sas_i, b_sas_i,
    output busy_sas_o, done_sas_o, final_sum_o, ovf_sas_o
  );
endinterface

// File: rtl/serial_addsub_engine.sv
// Digit-serial add/sub, LSD first; result after STEPS+1 edges, start ignored while busy (no queuing).
// SAS_ACCUM_EN adds acc_sas_i: B is taken from the previous result for chained accumulation.
module serial_addsub_engine #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                 clock_sas_i,
  input  logic                 reset_sas_i,
  serial_addsub_engine_if.slave sas
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             start_acc, last_step;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next, b_src;
  logic             mode_q, carry_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   final_sum_q;
  logic [DIGIT-1:0] b_digit;
  logic [DIGIT:0]   dsum;
  logic             ovf_next;

  always_ff @(posedge clock_sas_i) begin
    if (reset_sas_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: if (sas.start_sas_i) begin
        start_acc = 1'b1;
        state_d   = RUN;
      end
      RUN: if (cnt_q == LAST_CNT) begin
        last_step = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        start_acc = sas.start_sas_i;
        state_d   = sas.start_sas_i ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SAS_ACCUM_EN
  assign b_src = sas.acc_sas_i ? final_sum_q[WIDTH-1:0] : sas.b_sas_i;
`else
  assign b_src = sas.b_sas_i;
`endif

  // Subtract is A + ~B + 1: the +1 comes from the carry preset to mode at capture.
  assign b_digit = b_q[DIGIT-1:0] ^ {DIGIT{mode_q}};
  assign dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_digit} + {{DIGIT{1'b0}}, carry_q};
  // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
  assign ovf_next = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_digit[DIGIT-1] ^ dsum[DIGIT];

  generate
    if (DIGIT < WIDTH) begin : g_shift
      assign res_next = {dsum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end else begin : g_whole
      assign res_next = dsum[DIGIT-1:0];
    end
  endgenerate

  always_ff @(posedge clock_sas_i) begin
    if (reset_sas_i) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      final_sum_q <= '0;
      ovf_q       <= 1'b0;
    end else if (start_acc) begin
      a_q     <= sas.a_sas_i;
      b_q     <= b_src;
      mode_q  <= sas.mode_sas_i;
      carry_q <= sas.mode_sas_i;
      res_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      res_q   <= res_next;
      carry_q <= dsum[DIGIT];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_step) begin
        final_sum_q <= {dsum[DIGIT] ^ mode_q, res_next};
        ovf_q       <= ovf_next;
      end
    end
  end

  assign sas.busy_sas_o  = (state_q == RUN);
  assign sas.done_sas_o  = (state_q == DONE);
  assign sas.final_sum_o = final_sum_q;
  assign sas.ovf_sas_o   = ovf_q;
endmodule

// File: tb/tb_serial_addsub_engine.sv
// Directed bench for serial_addsub_engine: DIGIT=1 and DIGIT=4 instances, WIDTH=8.
module tb_serial_addsub_engine;
  logic clk = 1'b0;
  logic rst;
  logic acc_req;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_addsub_engine_if #(.WIDTH(8)) i1 ();
  serial_addsub_engine_if #(.WIDTH(8)) i4 ();

  serial_addsub_engine #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clock_sas_i(clk), .reset_sas_i(rst), .sas(i1)
  );
  serial_addsub_engine #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clock_sas_i(clk), .reset_sas_i(rst), .sas(i4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One DIGIT=1 operation: start on a falling edge, scramble inputs after capture, time the done pulse.
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic m,
                    input logic [8:0] es, input logic eo);
    int n;
    int bc;
    @(negedge clk);
    i1.start_sas_i = 1'b1;
    i1.a_sas_i = a;
    i1.b_sas_i = b;
    i1.mode_sas_i = m;
`ifdef SAS_ACCUM_EN
    i1.acc_sas_i = acc_req;
`endif
    @(negedge clk);
    i1.start_sas_i = 1'b0;
    i1.a_sas_i = ~a;
    i1.b_sas_i = ~b;
    i1.mode_sas_i = ~m;
    n = 0;
    bc = 0;
    while (!i1.done_sas_o && n < 20) begin
      if (i1.busy_sas_o) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busycnt"}, bc, 8);
    chk({tag, "_busy_in_done"}, {31'b0, i1.busy_sas_o}, 0);
    chk({tag, "_sum"}, {23'b0, i1.final_sum_o}, {23'b0, es});
    chk({tag, "_ovf"}, {31'b0, i1.ovf_sas_o}, {31'b0, eo});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, i1.done_sas_o}, 0);
    chk({tag, "_hold"}, {23'b0, i1.final_sum_o}, {23'b0, es});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t;
    int dc;
    rst = 1'b1;
    acc_req = 1'b0;
    i1.start_sas_i = 1'b0; i1.mode_sas_i = 1'b0; i1.a_sas_i = '0; i1.b_sas_i = '0;
    i4.start_sas_i = 1'b0; i4.mode_sas_i = 1'b0; i4.a_sas_i = '0; i4.b_sas_i = '0;
`ifdef SAS_ACCUM_EN
    i1.acc_sas_i = 1'b0;
    i4.acc_sas_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, i1.busy_sas_o}, 0);
    chk("rst_done", {31'b0, i1.done_sas_o}, 0);
    chk("rst_sum", {23'b0, i1.final_sum_o}, 0);
    chk("rst_ovf", {31'b0, i1.ovf_sas_o}, 0);
    chk("rst_sum4", {23'b0, i4.final_sum_o}, 0);
    rst = 1'b0;

    op("add235_251", 8'd235, 8'd251, 1'b0, 9'h1E6, 1'b0);
    op("sub100_30",  8'd100, 8'd30,  1'b1, 9'h046, 1'b0);
    op("sub30_100",  8'd30,  8'd100, 1'b1, 9'h1BA, 1'b0);
    op("add7F_01",   8'h7F,  8'h01,  1'b0, 9'h080, 1'b1);
    op("sub80_01",   8'h80,  8'h01,  1'b1, 9'h07F, 1'b1);
    op("addFF_01",   8'hFF,  8'h01,  1'b0, 9'h100, 1'b0);

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    i1.start_sas_i = 1'b1; i1.a_sas_i = 8'h10; i1.b_sas_i = 8'h20; i1.mode_sas_i = 1'b0;
    @(negedge clk);
    i1.start_sas_i = 1'b0;
    t = 0;
    repeat (2) @(negedge clk);
    t = 2;
    i1.start_sas_i = 1'b1; i1.a_sas_i = 8'hAA; i1.b_sas_i = 8'h55; i1.mode_sas_i = 1'b1;
    @(negedge clk);
    t = 3;
    i1.start_sas_i = 1'b0;
    while (!i1.done_sas_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ign_lat", t, 8);
    chk("ign_sum", {23'b0, i1.final_sum_o}, 32'h030);
    @(negedge clk);
    chk("ign_no_restart", {31'b0, i1.busy_sas_o}, 0);

    // Reset sampled on edge 4 of a run.
    @(negedge clk);
    i1.start_sas_i = 1'b1; i1.a_sas_i = 8'h7F; i1.b_sas_i = 8'h01; i1.mode_sas_i = 1'b0;
    @(negedge clk);
    i1.start_sas_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, i1.busy_sas_o}, 0);
    chk("midrst_done", {31'b0, i1.done_sas_o}, 0);
    chk("midrst_sum", {23'b0, i1.final_sum_o}, 0);
    chk("midrst_ovf", {31'b0, i1.ovf_sas_o}, 0);
    rst = 1'b0;
    dc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (i1.done_sas_o) dc++;
    end
    chk("midrst_nodone", dc, 0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    rst = 1'b1;
    i1.start_sas_i = 1'b1; i1.a_sas_i = 8'h01; i1.b_sas_i = 8'h01;
    @(negedge clk);
    chk("rststart_busy", {31'b0, i1.busy_sas_o}, 0);
    rst = 1'b0;
    i1.start_sas_i = 1'b0;
    @(negedge clk);
    chk("rststart_idle", {31'b0, i1.busy_sas_o}, 0);
    chk("rststart_done", {31'b0, i1.done_sas_o}, 0);

    // DIGIT=4: two-step run, then back-to-back start in the DONE cycle.
    @(negedge clk);
    i4.start_sas_i = 1'b1; i4.a_sas_i = 8'hFF; i4.b_sas_i = 8'h01; i4.mode_sas_i = 1'b0;
    @(negedge clk);
    i4.start_sas_i = 1'b0;
    chk("d4_busy_e0", {31'b0, i4.busy_sas_o}, 1);
    @(negedge clk);
    chk("d4_busy_e1", {31'b0, i4.busy_sas_o}, 1);
    chk("d4_nodone_e1", {31'b0, i4.done_sas_o}, 0);
    @(negedge clk);
    chk("d4_done_e2", {31'b0, i4.done_sas_o}, 1);
    chk("d4_busy_e2", {31'b0, i4.busy_sas_o}, 0);
    chk("d4_sum1", {23'b0, i4.final_sum_o}, 32'h100);
    i4.start_sas_i = 1'b1; i4.a_sas_i = 8'h20; i4.b_sas_i = 8'h30;
    @(negedge clk);
    i4.start_sas_i = 1'b0;
    chk("d4_b2b_busy", {31'b0, i4.busy_sas_o}, 1);
    chk("d4_b2b_hold", {23'b0, i4.final_sum_o}, 32'h100);
    @(negedge clk);
    chk("d4_b2b_busy2", {31'b0, i4.busy_sas_o}, 1);
    @(negedge clk);
    chk("d4_b2b_done", {31'b0, i4.done_sas_o}, 1);
    chk("d4_b2b_sum", {23'b0, i4.final_sum_o}, 32'h050);
    chk("d4_b2b_ovf", {31'b0, i4.ovf_sas_o}, 0);
    @(negedge clk);
    chk("d4_done_pulse", {31'b0, i4.done_sas_o}, 0);

`ifdef SAS_ACCUM_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_req = 1'b0;
    op("acc_10_5", 8'd10, 8'd5, 1'b0, 9'h00F, 1'b0);
    acc_req = 1'b1;
    op("acc_add20", 8'd20, 8'h99, 1'b0, 9'h023, 1'b0);
    op("acc_subF0", 8'hF0, 8'h99, 1'b1, 9'h0CD, 1'b0);
    acc_req = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
